// File: rtl/vga_timing_gen_if.sv
// Raster-timing bundle between the VGA timing generator and the pixel path.
// master: the timing generator (drives counters, strobes and connector pins).
// slave:  the address-generator/ROM side (supplies pixel colour).
interface vga_timing_gen_if;
  logic [11:0] pixel_in;     // {R,G,B} from the image ROM
  logic        pclk_en;      // pixel-tick strobe
  logic [9:0]  h_cnt;        // current pixel column
  logic [9:0]  v_cnt;        // current line
  logic        valid;        // undelayed active-video flag
  logic        line_start;   // one-clk pulse at h_cnt wrap
  logic        frame_start;  // one-clk pulse at (0,0)
  logic        hsync;        // delayed, active-low
  logic        vsync;        // delayed, active-low
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;

  modport master (
    input  pixel_in,
    output pclk_en, h_cnt, v_cnt, valid, line_start, frame_start,
    output hsync, vsync, vga_r, vga_g, vga_b
  );

  modport slave (
    output pixel_in,
    input  pclk_en, h_cnt, v_cnt, valid, line_start, frame_start,
    input  hsync, vsync, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Divides the system clock down to a pixel tick, runs the horizontal and
// vertical counters that feed the pixel-address generators, decodes sync and
// active video, and delays those decodes by PIPE_DLY ticks so they line up
// with colour coming back from the image ROM. The final colour register is
// blanked whenever the delayed active-video flag is low.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIPE_DLY = 2   // legal range 1..4
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [9:0] HMax     = 10'(H_TOTAL - 1);
  localparam logic [9:0] VMax     = 10'(V_TOTAL - 1);
  localparam logic [9:0] HDisp    = 10'(H_DISP);
  localparam logic [9:0] VDisp    = 10'(V_DISP);
  localparam logic [9:0] HsFirst  = 10'(H_DISP + H_FP);
  localparam logic [9:0] HsLast   = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VsFirst  = 10'(V_DISP + V_FP);
  localparam logic [9:0] VsLast   = 10'(V_DISP + V_FP + V_SYNC - 1);

  // One delay-line entry: active-low syncs plus the active-video flag.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } tap_t;

  localparam tap_t TapIdle = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      h_q, h_d;
  logic [9:0]      v_q, v_d;
  logic            run_q, run_d;
  logic [11:0]     rgb_q, rgb_d;
  logic            tick;
  tap_t            raw;
  tap_t            stage_q [PIPE_DLY];
  // taps[0] is the undelayed decode, taps[k] the output of delay stage k.
  tap_t            taps    [PIPE_DLY+1];

  // Pixel tick on the last clock of each divider period.
  always_comb begin
    tick = (div_q == DivMax);
  end

  // Next-state for divider, raster counters and the started flag.
  always_comb begin
    div_d = tick ? '0 : div_q + DivW'(1);
    h_d   = h_q;
    v_d   = v_q;
    run_d = run_q;
    if (tick) begin
      // run_q masks the start pulses for the reset-forced (0,0).
      run_d = 1'b1;
      if (h_q == HMax) begin
        h_d = '0;
        v_d = (v_q == VMax) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Sync and active-video decode, same cycle as the counters.
  always_comb begin
    raw.act = (h_q < HDisp) && (v_q < VDisp);
    raw.hs  = !((h_q >= HsFirst) && (h_q <= HsLast));
    raw.vs  = !((v_q >= VsFirst) && (v_q <= VsLast));
  end

  // Flatten undelayed decode and delay stages into one indexable chain.
  always_comb begin
    taps[0] = raw;
    for (int i = 1; i <= PIPE_DLY; i++) begin
      taps[i] = stage_q[i-1];
    end
  end

  // Colour loads together with the last delay stage, gated by the valid bit
  // that is about to enter that stage so colour and syncs stay aligned.
  always_comb begin
    rgb_d = rgb_q;
    if (tick) begin
      rgb_d = taps[PIPE_DLY-1].act ? bus.pixel_in : 12'h000;
    end
  end

  // Divider, counters and started flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      run_q <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      run_q <= run_d;
    end
  end

  // Sync/valid delay line, shifting once per pixel tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DLY; i++) begin
        stage_q[i] <= TapIdle;
      end
    end else if (tick) begin
      for (int i = 0; i < PIPE_DLY; i++) begin
        stage_q[i] <= taps[i];
      end
    end
  end

  // Gated colour register driving the connector.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  // Counter-side and connector-side outputs.
  always_comb begin
    bus.pclk_en     = tick;
    bus.h_cnt       = h_q;
    bus.v_cnt       = v_q;
    bus.valid       = raw.act;
    bus.line_start  = run_q && (div_q == '0) && (h_q == '0);
    bus.frame_start = run_q && (div_q == '0) && (h_q == '0) && (v_q == '0);
    bus.hsync       = stage_q[PIPE_DLY-1].hs;
    bus.vsync       = stage_q[PIPE_DLY-1].vs;
    bus.vga_r       = rgb_q[11:8];
    bus.vga_g       = rgb_q[7:4];
    bus.vga_b       = rgb_q[3:0];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster so several
// frames fit in a short run. Expected values come from tick arithmetic
// (tick index -> raster position) plus a history of the random colours driven.
module tb_vga_timing_gen;

  localparam int CD = 4;
  localparam int HD = 16, HF = 2, HS = 4, HB = 3;
  localparam int VD = 6,  VF = 2, VS = 2, VB = 2;
  localparam int P  = 2;
  localparam int HT = HD + HF + HS + HB;  // 25
  localparam int VT = VD + VF + VS + VB;  // 12

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_timing_gen_if bus ();

  vga_timing_gen #(
    .CLK_DIV (CD),
    .H_DISP  (HD),
    .H_FP    (HF),
    .H_SYNC  (HS),
    .H_BP    (HB),
    .V_DISP  (VD),
    .V_FP    (VF),
    .V_SYNC  (VS),
    .V_BP    (VB),
    .PIPE_DLY(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int c      = 0;   // clk edges since the last reset edge
  int hist[int];    // colour driven for raster tick index
  int hs_fall, vs_fall, fs_last;
  logic hs_prev, vs_prev;

  typedef struct {
    int   tick;
    int   h;
    int   v;
    logic vld;
    logic hs;
    logic vs;
  } vec_t;

  vec_t tbl[$];

  function automatic int pos_h(int p);
    return p % HT;
  endfunction

  function automatic int pos_v(int p);
    return (p / HT) % VT;
  endfunction

  function automatic int pos_valid(int p);
    return int'(pos_h(p) < HD && pos_v(p) < VD);
  endfunction

  function automatic int pos_hs(int p);
    return int'(!(pos_h(p) >= HD + HF && pos_h(p) < HD + HF + HS));
  endfunction

  function automatic int pos_vs(int p);
    return int'(!(pos_v(p) >= VD + VF && pos_v(p) < VD + VF + VS));
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) begin
      passes++;
    end else begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0d expected %0d (clk %0d after reset)", name, got, exp, c);
    end
  endtask

  task automatic model_check();
    int n, ph, eh, ev, ls, ehs, evs, ergb;
    n  = c / CD;
    ph = c % CD;
    eh = pos_h(n);
    ev = pos_v(n);
    ls = int'(ph == 0 && n > 0 && eh == 0);
    chk("pclk_en", int'(bus.pclk_en), int'(ph == CD - 1));
    chk("h_cnt", int'(bus.h_cnt), eh);
    chk("v_cnt", int'(bus.v_cnt), ev);
    chk("valid", int'(bus.valid), pos_valid(n));
    chk("line_start", int'(bus.line_start), ls);
    chk("frame_start", int'(bus.frame_start), int'(ls != 0 && ev == 0));
    if (n < P) begin
      ehs = 1; evs = 1; ergb = 0;
    end else begin
      ehs  = pos_hs(n - P);
      evs  = pos_vs(n - P);
      ergb = pos_valid(n - P) != 0 ? hist[n - P] : 0;
    end
    chk("hsync", int'(bus.hsync), ehs);
    chk("vsync", int'(bus.vsync), evs);
    chk("rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}), ergb);
  endtask

  task automatic measure();
    if (hs_prev && !bus.hsync) hs_fall = c;
    if (!hs_prev && bus.hsync && hs_fall >= 0) chk("hsync_low_clks", c - hs_fall, HS * CD);
    hs_prev = bus.hsync;
    if (vs_prev && !bus.vsync) vs_fall = c;
    if (!vs_prev && bus.vsync && vs_fall >= 0)
      chk("vsync_low_clks", c - vs_fall, VS * HT * CD);
    vs_prev = bus.vsync;
    if (bus.frame_start) begin
      if (fs_last >= 0) chk("frame_period_clks", c - fs_last, HT * VT * CD);
      fs_last = c;
    end
  endtask

  // pixel_in carries the colour for the position PIPE_DLY-1 ticks behind the counters.
  task automatic drive_pixel();
    int p;
    p = c / CD - (P - 1);
    if (p >= 0) begin
      if (!hist.exists(p)) hist[p] = int'($urandom_range(0, 4095));
      bus.pixel_in = 12'(hist[p]);
    end else begin
      bus.pixel_in = 12'($urandom_range(0, 4095));
    end
  endtask

  task automatic step();
    @(posedge clk);
    c++;
    #1;
    model_check();
    measure();
    drive_pixel();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_h_cnt", int'(bus.h_cnt), 0);
    chk("rst_v_cnt", int'(bus.v_cnt), 0);
    chk("rst_hsync", int'(bus.hsync), 1);
    chk("rst_vsync", int'(bus.vsync), 1);
    chk("rst_rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
    chk("rst_pclk_en", int'(bus.pclk_en), 0);
    chk("rst_line_start", int'(bus.line_start), 0);
    chk("rst_frame_start", int'(bus.frame_start), 0);
    c = 0;
    hist.delete();
    hs_fall = -1;
    vs_fall = -1;
    fs_last = -1;
    hs_prev = 1'b1;
    vs_prev = 1'b1;
    drive_pixel();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    bus.pixel_in = 12'h000;

    // tick, h, v, valid, hsync, vsync (syncs reflect position tick-P)
    tbl.push_back('{1,   1,  0,  1'b1, 1'b1, 1'b1});
    tbl.push_back('{19,  19, 0,  1'b0, 1'b1, 1'b1});
    tbl.push_back('{20,  20, 0,  1'b0, 1'b0, 1'b1});
    tbl.push_back('{23,  23, 0,  1'b0, 1'b0, 1'b1});
    tbl.push_back('{24,  24, 0,  1'b0, 1'b1, 1'b1});
    tbl.push_back('{25,  0,  1,  1'b1, 1'b1, 1'b1});
    tbl.push_back('{140, 15, 5,  1'b1, 1'b1, 1'b1});
    tbl.push_back('{141, 16, 5,  1'b0, 1'b1, 1'b1});
    tbl.push_back('{150, 0,  6,  1'b0, 1'b1, 1'b1});
    tbl.push_back('{201, 1,  8,  1'b0, 1'b1, 1'b1});
    tbl.push_back('{202, 2,  8,  1'b0, 1'b1, 1'b0});
    tbl.push_back('{251, 1,  10, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{252, 2,  10, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{299, 24, 11, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{300, 0,  0,  1'b1, 1'b1, 1'b1});

    do_reset(3);

    // First tick: strobe on the CD-th clock, counter steps to 1 on that edge.
    repeat (CD - 1) step();
    chk("first_pclk_en", int'(bus.pclk_en), 1);
    step();
    chk("first_h_cnt", int'(bus.h_cnt), 1);

    foreach (tbl[i]) begin
      while (c < tbl[i].tick * CD) step();
      chk($sformatf("tbl%0d_h", i), int'(bus.h_cnt), tbl[i].h);
      chk($sformatf("tbl%0d_v", i), int'(bus.v_cnt), tbl[i].v);
      chk($sformatf("tbl%0d_valid", i), int'(bus.valid), int'(tbl[i].vld));
      chk($sformatf("tbl%0d_hsync", i), int'(bus.hsync), int'(tbl[i].hs));
      chk($sformatf("tbl%0d_vsync", i), int'(bus.vsync), int'(tbl[i].vs));
    end

    // Two more frames with random colour to exercise wraps and sync widths.
    while (c < 3 * HT * VT * CD + 40) step();

    // Reset in the middle of a line while hsync is low.
    guard = 0;
    while (!(pos_h(c / CD) == 20 && pos_v(c / CD) == 3 && c % CD == 0) && guard < 4 * HT * VT * CD) begin
      step();
      guard++;
    end
    chk("midline_reached", int'(guard < 4 * HT * VT * CD), 1);
    chk("midline_h", int'(bus.h_cnt), 20);
    chk("midline_hsync_low", int'(bus.hsync), 0);
    do_reset(1);

    // Normal timing resumes from (0,0).
    while (c < 2 * HT * VT * CD + 40) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock. Drives `h_cnt`/`v_cnt` into the pixel-address generators, then re-aligns sync and active-video with the image-ROM read latency. Outputs the final gated 12-bit colour to the VGA connector. It is the counter-producing and pixel-consuming end of the address-generator/ROM path.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; a pixel tick occurs every CLK_DIV clocks.
- `H_DISP`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_DISP`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `PIPE_DLY`, 2: pixel-tick latency from `h_cnt`/`v_cnt` to the connector outputs; legal range 1..4.
- `clk  in  1`: system clock, 100 MHz.
- `rst  in  1`: synchronous, active-high reset.
- `pixel_in  in  12`: {R[3:0],G[3:0],B[3:0]} from the image ROM.
- `pclk_en  out  1`: pixel-tick strobe, one clk wide.
- `h_cnt  out  10`: current pixel column, 0..H_TOTAL-1 (H_TOTAL = 800).
- `v_cnt  out  10`: current line, 0..V_TOTAL-1 (V_TOTAL = 525).
- `valid  out  1`: undelayed active-video flag for the current counter values.
- `line_start  out  1`: one-clk pulse when `h_cnt` wraps to 0.
- `frame_start  out  1`: one-clk pulse when both counters wrap to (0,0).
- `hsync  out  1`: delayed horizontal sync, active-low.
- `vsync  out  1`: delayed vertical sync, active-low.
- `vga_r  out  4`: delayed, gated red.
- `vga_g  out  4`: delayed, gated green.
- `vga_b  out  4`: delayed, gated blue.

## Operation
- **Divider:**
  - `div` counts 0..CLK_DIV-1 and wraps.
  - `pclk_en` = (div == CLK_DIV-1).
  - All remaining state advances only on clk edges where `pclk_en` = 1.
- **Horizontal counter:** `h_cnt` increments per tick; at H_TOTAL-1 it wraps to 0.
- **Vertical counter:**
  - `v_cnt` increments on the tick where `h_cnt` wraps.
  - At V_TOTAL-1 it wraps to 0.
  - When h = 799 and v = 524 on the same tick, both go to 0.
- **Decodes (combinational, same-cycle with the counters):**
  - `valid` = (h_cnt < H_DISP) && (v_cnt < V_DISP).
  - hs_raw low for h_cnt in [656, 751].
  - vs_raw low for v_cnt in [490, 491].
- **Start pulses:**
  - `line_start` is high for the single clk in which the registered `h_cnt` = 0 and div = 0.
  - `frame_start` is the same with `v_cnt` = 0 additionally.
- **Delay line:**
  - A PIPE_DLY-stage shift register carries {hs_raw, vs_raw, valid}, shifting on `pclk_en`.
  - `hsync`/`vsync` are the last stage.
- **Colour output:**
  - On the same `pclk_en` edge that loads the last stage, the colour register loads `pixel_in` if stage PIPE_DLY-1's valid bit = 1, else 0.
  - When PIPE_DLY = 1, "stage 0" means the undelayed `valid`.
- **Upstream contract:** `pixel_in` must hold the colour for the counter value that was present PIPE_DLY-1 ticks earlier, stable at that `pclk_en` edge.
- **Blanking:** colour is forced to 0 whenever the delayed valid = 0, including porches and sync.

## Timing
- **Reset values** (rst high at a clk edge; values take effect at that edge):
  - div = 0, `h_cnt` = 0, `v_cnt` = 0.
  - All delay stages = {1, 1, 0}.
  - `hsync` = 1, `vsync` = 1.
  - `vga_r`/`vga_g`/`vga_b` = 0.
  - `pclk_en` = 0, `line_start` = 0, `frame_start` = 0.
- **First tick after reset:**
  - The first `pclk_en` asserts CLK_DIV clks after rst deasserts.
  - `h_cnt` becomes 1 at that edge.
  - No `line_start` or `frame_start` pulse is emitted for the reset-forced (0,0).
- **Reset mid-frame:** counters, delay line and outputs return to reset values on the next edge; no partial sync pulse is stretched.
- **Latency:**
  - `hsync`, `vsync` and colour lag the counters by exactly PIPE_DLY pixel ticks (PIPE_DLY*CLK_DIV clks).
  - All three change on the same clk edge.
- **Frame timing:**
  - 800*525 ticks = 1,680,000 clks at CLK_DIV = 4.
  - The hsync low period is exactly 96 ticks; the vsync low period is exactly 2 lines (1600 ticks).

## Test plan
- **Reset:** hold rst 3 clks → all outputs at their reset values; release → first `pclk_en` 4 clks later, `h_cnt` = 1.
- **Line wrap:** run to h = 799, v = 10 → next tick gives h = 0, v = 11, one `line_start` pulse; `pclk_en` period is 4 clks throughout.
- **Hsync window (PIPE_DLY = 2):** `hsync` falls 2 ticks after h_cnt = 656, stays low exactly 96 ticks; `vsync` low for 1600 ticks starting 2 ticks after v = 490, h = 0.
- **Frame wrap:** h = 799, v = 524 → (0,0) with one `frame_start` pulse; consecutive `frame_start` pulses are 1,680,000 clks apart.
- **Pixel alignment:**
  - Drive `pixel_in` = h_cnt[11:0] delayed 1 tick.
  - In the visible area, {vga_r, vga_g, vga_b} equals the column value PIPE_DLY ticks earlier.
  - At column 640 onward and on lines ≥ 480, colour = 0.
- **Reset mid-line:** assert rst at h = 700, v = 300 → next clk gives h = 0, v = 0, `hsync` = 1, colour = 0; normal timing resumes.
